pixels_to_vector: RTL and testbench
===================================

// Module: pixels_to_vector
// PURPOSE
// Encoder side of the binarized-image path: consumes a raster stream of grayscale pixels
// (IMG_W x IMG_H), averages each BLK x BLK block, thresholds each mean and packs the
// results into a 48-bit vector (bit = block_y*8 + block_x, 1 = white) for the VGA
// block renderer and downstream classification. Tolerates gaps in the stream.
// PARAMETERS
// IMG_W   160  pixels per line
// IMG_H   120  lines per frame
// BLK     20   block edge in pixels; IMG_W/BLK = 8 cols, IMG_H/BLK = 6 rows, 48 bits
// PIX_W   8    grayscale pixel width
// PORTS
// clk        in   1      single clock; all logic rising-edge
// reset      in   1      synchronous, active-high
// pix_valid  in   1      pixel qualifier; pixel accepted on any cycle it is high
// pix_sof    in   1      with pix_valid: this pixel is (x=0,y=0) of a new frame
// pix_data   in   PIX_W  grayscale value
// thresh     in   PIX_W  binarization threshold; sampled when the SOF pixel is accepted
// vec_48     out  48     last completed frame's vector; held until next frame completes
// vec_valid  out  1      one-cycle pulse when vec_48 updates
// busy       out  1      high while a frame is being accumulated
// frame_err  out  1      one-cycle pulse when a frame is aborted by an early pix_sof
// BEHAVIOUR
// - Reset: vec_48=0, vec_valid=0, busy=0, frame_err=0; x/y counters, accumulators,
//   working vector cleared; state=IDLE. Reset mid-frame discards the partial frame.
// - States: IDLE (ignore pixels until pix_valid&pix_sof) -> ACCUM -> DONE -> IDLE/ACCUM.
// - ACCUM: x counts 0..IMG_W-1 per accepted pixel, y increments on x wrap; block_x=x/BLK.
//   8 column accumulators, each 17 bits (400*255=102000 fits; no saturation needed).
//   Accepted pixel adds pix_data to accumulator[block_x].
// - Block-row close: pixel with x=IMG_W-1 and y%BLK==BLK-1 sets row_done (registered).
//   Next cycle: for each column c, bit[row*8+c] of working vector = (acc[c] >= thresh_q*BLK*BLK)
//   (compare at full width, >= means equal sets the bit); all accumulators cleared. If a
//   pixel is accepted in that same cycle, its column loads pix_data instead of adding.
// - Frame close: after the compare of row 5 (y=IMG_H-1) state=DONE for one cycle:
//   vec_48 <= working vector, vec_valid=1. Pixel (IMG_W-1,IMG_H-1) accepted at edge T:
//   row compare at edge T+1, vec_48/vec_valid update at edge T+2 (latency 2).
// - pix_sof handling: SOF in IDLE/DONE starts a frame (busy=1 from next cycle). SOF while
//   in ACCUM before frame close: frame_err pulse, partial data discarded, that pixel taken
//   as (0,0) of new frame with new thresh; vec_48 unchanged, no vec_valid.
//   SOF arriving in the row-compare or DONE cycle of a completing frame: completion still
//   happens (vec_valid pulses), SOF pixel starts the next frame; no frame_err.
// - Pixels with pix_valid high but no SOF while IDLE are dropped.
// - busy=1 in ACCUM and through the final compare; 0 in IDLE and from the DONE cycle on.
// TESTING
// 1 SOF + 19200 pixels all 255, thresh=128 -> vec_valid one pulse 2 cycles after last
//   pixel, vec_48=48'hFFFF_FFFF_FFFF; all-zero frame -> vec_48=0.
// 2 Frame 0 except block (bx=3,by=2) all 200, thresh=100 -> vec_48 has only bit 19 set.
// 3 Boundary: block 0 sum exactly 128*400 (all 128), thresh=128 -> bit0=1; one pixel 127
//   -> bit0=0; check no overflow with block of 255s at thresh=255 -> bit=1.
// 4 Random pix_valid gaps (~50% duty) with pattern of test 2 -> identical vec_48.
// 5 SOF at pixel 5000 of a frame -> frame_err pulse, no vec_valid, vec_48 holds prior
//   value; following full frame -> correct vector.
// 6 reset asserted mid-frame then pixels without SOF -> outputs stay 0, busy=0; next SOF
//   frame completes normally. Back-to-back frames (SOF next cycle after last pixel) -> both
//   vec_valid pulses, no frame_err.

Source files
------------

// File: rtl/pixels_to_vector.sv
// Block-mean binarizer: averages each BLK x BLK block of a raster grayscale frame,
// thresholds the means and publishes one bit per block (bit = by*NCOL + bx, 1 = white).
module pixels_to_vector #(
  parameter int unsigned IMG_W = 160,
  parameter int unsigned IMG_H = 120,
  parameter int unsigned BLK   = 20,
  parameter int unsigned PIX_W = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      pix_valid,
  input  logic                                      pix_sof,
  input  logic [PIX_W-1:0]                          pix_data,
  input  logic [PIX_W-1:0]                          thresh,
  output logic [(IMG_W/BLK)*(IMG_H/BLK)-1:0]        vec_48,
  output logic                                      vec_valid,
  output logic                                      busy,
  output logic                                      frame_err
);

  localparam int unsigned NCOL  = IMG_W / BLK;
  localparam int unsigned NROW  = IMG_H / BLK;
  localparam int unsigned VEC_W = NCOL * NROW;
  localparam int unsigned ACC_W = $clog2(BLK * BLK * ((1 << PIX_W) - 1) + 1);
  localparam int unsigned CX_W  = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int unsigned RY_W  = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int unsigned S_W   = (BLK > 1) ? $clog2(BLK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t             state;
  logic [CX_W-1:0]    bx;
  logic [S_W-1:0]     sx;
  logic [RY_W-1:0]    by;
  logic [S_W-1:0]     sy;
  logic [ACC_W-1:0]   acc [NCOL];
  logic               row_done;
  logic [RY_W-1:0]    row_idx;
  logic               last_row;
  logic [PIX_W-1:0]   thresh_q;
  logic [VEC_W-1:0]   work_vec;
  logic [VEC_W-1:0]   pend_vec;
  logic               publish;

  logic               start;
  logic               closing;
  logic               accept;
  logic [ACC_W-1:0]   thr_full;
  logic [NCOL-1:0]    row_bits;
  logic [VEC_W-1:0]   work_next;

  // closing = the compare cycle of the final block row; the old frame is already complete
  assign start   = pix_valid && pix_sof;
  assign closing = row_done && last_row;
  assign accept  = pix_valid && !pix_sof && (state == S_ACCUM) && !closing;

  // Compare block sums against thresh*BLK*BLK so no division is needed
  always_comb begin
    thr_full  = ACC_W'(thresh_q) * ACC_W'(BLK * BLK);
    row_bits  = '0;
    work_next = work_vec;
    for (int c = 0; c < NCOL; c++) row_bits[c] = (acc[c] >= thr_full);
    for (int r = 0; r < NROW; r++) begin
      if (row_idx == RY_W'(r)) work_next[r*NCOL +: NCOL] = row_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bx        <= '0;
      sx        <= '0;
      by        <= '0;
      sy        <= '0;
      for (int c = 0; c < NCOL; c++) acc[c] <= '0;
      row_done  <= 1'b0;
      row_idx   <= '0;
      last_row  <= 1'b0;
      thresh_q  <= '0;
      work_vec  <= '0;
      pend_vec  <= '0;
      publish   <= 1'b0;
      vec_48    <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vec_valid <= 1'b0;
      frame_err <= 1'b0;
      publish   <= 1'b0;

      if (publish) begin
        vec_48    <= pend_vec;
        vec_valid <= 1'b1;
      end

      // Row compare; the finished vector is staged separately so a new frame may start now
      if (row_done) begin
        row_done <= 1'b0;
        work_vec <= work_next;
        for (int c = 0; c < NCOL; c++) acc[c] <= '0;
        if (last_row) begin
          pend_vec <= work_next;
          publish  <= 1'b1;
        end
      end

      if (start) begin
        frame_err <= (state == S_ACCUM) && !closing;
        thresh_q  <= thresh;
        work_vec  <= '0;
        row_done  <= 1'b0;
        last_row  <= 1'b0;
        for (int c = 0; c < NCOL; c++) acc[c] <= '0;
        acc[0]    <= ACC_W'(pix_data);
        bx        <= '0;
        sx        <= S_W'(1);
        by        <= '0;
        sy        <= '0;
        state     <= S_ACCUM;
        busy      <= 1'b1;
      end else begin
        if (accept) begin
          acc[bx] <= (row_done ? ACC_W'(0) : acc[bx]) + ACC_W'(pix_data);
          if (sx == S_W'(BLK - 1)) begin
            sx <= '0;
            if (bx == CX_W'(NCOL - 1)) begin
              bx <= '0;
              if (sy == S_W'(BLK - 1)) begin
                sy       <= '0;
                row_done <= 1'b1;
                row_idx  <= by;
                last_row <= (by == RY_W'(NROW - 1));
                by       <= (by == RY_W'(NROW - 1)) ? RY_W'(0) : by + RY_W'(1);
              end else begin
                sy <= sy + S_W'(1);
              end
            end else begin
              bx <= bx + CX_W'(1);
            end
          end else begin
            sx <= sx + S_W'(1);
          end
        end
        if (closing) begin
          state <= S_DONE;
          busy  <= 1'b0;
        end else if (state == S_DONE) begin
          state <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixels_to_vector.sv
// Directed bench for pixels_to_vector: full frames, boundaries, gaps, abort, reset, back-to-back.
module tb_pixels_to_vector;

  localparam int unsigned IMG_W = 160;
  localparam int unsigned IMG_H = 120;
  localparam int unsigned NPIX  = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic        pix_sof;
  logic [7:0]  pix_data;
  logic [7:0]  thresh;
  logic [47:0] vec_48;
  logic        vec_valid;
  logic        busy;
  logic        frame_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          vv_count = 0;
  int          fe_count = 0;
  int          vv_cyc = 0;
  logic [47:0] vv_vec = '0;
  logic        vv_busy = 1'b0;
  int          last_drive = 0;
  int          f1_last, f2_last, f3_last;

  pixels_to_vector dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_data  (pix_data),
    .thresh    (thresh),
    .vec_48    (vec_48),
    .vec_valid (vec_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record output pulses away from the active edge
  always @(negedge clk) begin
    if (vec_valid) begin
      vv_count++;
      vv_cyc  = cyc;
      vv_vec  = vec_48;
      vv_busy = busy;
    end
    if (frame_err) fe_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 0: all 255; 1: block (3,2) = 200 else 0; 2: block0 = 128, block1 = 128 with one 127, block (7,5) = 255
  function automatic logic [7:0] pix_val(input int mode, input int x, input int y);
    case (mode)
      0: return 8'd255;
      1: return (x / 20 == 3 && y / 20 == 2) ? 8'd200 : 8'd0;
      2: begin
        if (x < 20 && y < 20) return 8'd128;
        if (x < 40 && y < 20) return (x == 20 && y == 0) ? 8'd127 : 8'd128;
        if (x >= 140 && y >= 100) return 8'd255;
        return 8'd0;
      end
      default: return 8'd0;
    endcase
  endfunction

  // thresh is scrambled after the SOF pixel so only the SOF-time value can matter
  task automatic send(input int mode, input logic [7:0] thr, input int npix,
                      input bit with_sof, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      if (gaps && i > 0) begin
        while ($urandom_range(1, 0) == 1) begin
          @(negedge clk);
          pix_valid = 1'b0;
          pix_sof   = 1'b0;
        end
      end
      @(negedge clk);
      pix_valid  = 1'b1;
      pix_sof    = with_sof && (i == 0);
      pix_data   = pix_val(mode, i % IMG_W, i / IMG_W);
      thresh     = (i == 0) ? thr : ~thr;
      last_drive = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; thresh = '0;
    repeat (3) @(negedge clk);
    check("rst_vec", vec_48, 0);
    check("rst_vv", vec_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    reset = 1'b0;

    // Reset mid-frame, then pixels without SOF must be ignored
    send(0, 8'd0, 1000, 1'b1, 1'b0);
    @(negedge clk);
    pix_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(0, 8'd0, 300, 1'b0, 1'b0);
    idle(4);
    check("midrst_busy", busy, 0);
    check("midrst_vec", vec_48, 0);
    check("midrst_vv", vv_count, 0);
    check("midrst_ferr", fe_count, 0);

    // All-white frame at the maximum threshold (sum 102000 == 255*400)
    fork
      send(0, 8'd255, NPIX, 1'b1, 1'b0);
      begin
        idle(0);
        repeat (50) @(negedge clk);
        check("f1_busy", busy, 1);
      end
    join
    f1_last = last_drive;

    // Back-to-back: gapped single-block frame starts the cycle after the last pixel
    fork
      send(1, 8'd100, NPIX, 1'b1, 1'b1);
      begin
        repeat (6) @(negedge clk);
        check("f1_vv_cnt", vv_count, 1);
        check("f1_latency", vv_cyc - f1_last, 3);
        check("f1_vec", vv_vec, 48'hFFFF_FFFF_FFFF);
        check("f1_ferr", fe_count, 0);
      end
    join
    f2_last = last_drive;
    idle(7);
    check("f2_vv_cnt", vv_count, 2);
    check("f2_latency", vv_cyc - f2_last, 3);
    check("f2_vec", vv_vec, 48'h0000_0008_0000);
    check("f2_ferr", fe_count, 0);
    check("f2_hold", vec_48, 48'h0000_0008_0000);

    // Abort after 5000 pixels; the SOF pixel starts the boundary frame
    send(0, 8'd0, 5000, 1'b1, 1'b0);
    fork
      send(2, 8'd128, NPIX, 1'b1, 1'b0);
      begin
        repeat (6) @(negedge clk);
        check("abort_ferr", fe_count, 1);
        check("abort_vv", vv_count, 2);
        check("abort_hold", vec_48, 48'h0000_0008_0000);
      end
    join
    f3_last = last_drive;
    idle(7);
    check("f3_vv_cnt", vv_count, 3);
    check("f3_latency", vv_cyc - f3_last, 3);
    check("f3_vec", vv_vec, 48'h8000_0000_0001);
    check("f3_busy_done", vv_busy, 0);
    check("f3_ferr", fe_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
